uart_tx_serializer: RTL and testbench



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_tx_serializer.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, parity-mode codes and data-length helpers for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE_S,
    START_S,
    DATA_S,
    PARITY_S,
    STOP_S
  } uart_tx_state_t;

  localparam logic [1:0] PAR_ODD   = 2'd0;
  localparam logic [1:0] PAR_EVEN  = 2'd1;
  localparam logic [1:0] PAR_SPACE = 2'd2;
  localparam logic [1:0] PAR_MARK  = 2'd3;

  // 2-bit length code to data-bit count (5..8).
  function automatic logic [3:0] data_len_bits(input logic [1:0] code);
    return 4'd5 + 4'(code);
  endfunction

  // Mask keeping only the bits that are actually transmitted.
  function automatic logic [7:0] data_len_mask(input logic [1:0] code);
    logic [7:0] mask;
    case (code)
      2'd0:    mask = 8'h1F;
      2'd1:    mask = 8'h3F;
      2'd2:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: o_tick is high in the last clock of every bit period.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] reload_q, reload_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Reload value is N-1 so a divisor of 0 behaves like 1.
  always_comb begin
    reload_d = reload_q;
    if (i_load) begin
      reload_d = (i_div == '0) ? '0 : i_div - DIV_W'(1);
    end
    if (i_load) begin
      cnt_d = reload_d;
    end else if (cnt_q == '0) begin
      cnt_d = reload_q;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      reload_q <= '0;
      cnt_q    <= '0;
      o_tick   <= 1'b0;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      o_tick   <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_din_8b,
  input  logic             i_din_valid,
  output logic             o_tx_busy,
  input  logic [DIV_W-1:0] i_baud_div,
  input  logic [1:0]       i_data_len,
  input  logic             i_stop_2b,
  input  logic             i_parity_en,
  input  logic [1:0]       i_parity_mode,
  output logic             o_txd,
  output logic             o_tx_done,
  output logic             o_overrun
);

  uart_tx_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] last_bit_q, last_bit_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       stop2_q, stop2_d;
  logic [7:0] data_q, data_d;
  logic       txd_d, busy_d, done_d, overrun_d;
  logic       accept_c;
  logic       tick;

  assign accept_c = (state_q == IDLE_S) && i_din_valid;

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (accept_c),
    .i_div  (i_baud_div),
    .o_tick (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic       par_en_q, par_en_d;
  logic [1:0] par_mode_q, par_mode_d;
  logic       parity_c;

  // data_q is already masked to the frame length.
  always_comb begin
    case (par_mode_q)
      PAR_ODD:   parity_c = ~^data_q;
      PAR_EVEN:  parity_c = ^data_q;
      PAR_SPACE: parity_c = 1'b0;
      default:   parity_c = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      par_en_q   <= 1'b0;
      par_mode_q <= PAR_ODD;
    end else begin
      par_en_q   <= par_en_d;
      par_mode_q <= par_mode_d;
    end
  end
`else
  logic unused_parity;
  assign unused_parity = ^{i_parity_en, i_parity_mode};
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    last_bit_d = last_bit_q;
    stop_cnt_d = stop_cnt_q;
    stop2_d    = stop2_q;
    data_d     = data_q;
    txd_d      = o_txd;
    busy_d     = o_tx_busy;
    done_d     = 1'b0;
    overrun_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_mode_d = par_mode_q;
`endif
    case (state_q)
      IDLE_S: begin
        if (i_din_valid) begin
          state_d    = START_S;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
          data_d     = i_din_8b & data_len_mask(i_data_len);
          last_bit_d = 3'(data_len_bits(i_data_len) - 4'd1);
          stop2_d    = i_stop_2b;
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_en_d   = i_parity_en;
          par_mode_d = i_parity_mode;
`endif
        end
      end
      START_S: begin
        if (tick) begin
          state_d = DATA_S;
          txd_d   = data_q[0];
        end
      end
      DATA_S: begin
        if (tick) begin
          if (bit_cnt_q == last_bit_q) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = PARITY_S;
              txd_d   = parity_c;
            end else begin
`else
            begin
`endif
              state_d = STOP_S;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = data_q[bit_cnt_d];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_S: begin
        if (tick) begin
          state_d = STOP_S;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP_S: begin
        if (tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = IDLE_S;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE_S;
        busy_d  = 1'b0;
        txd_d   = 1'b1;
      end
    endcase
    // Bytes offered mid-frame are dropped and flagged.
    if (i_din_valid && (state_q != IDLE_S)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE_S;
      bit_cnt_q  <= 3'd0;
      last_bit_q <= 3'd0;
      stop_cnt_q <= 1'b0;
      stop2_q    <= 1'b0;
      data_q     <= 8'd0;
      o_txd      <= 1'b1;
      o_tx_busy  <= 1'b0;
      o_tx_done  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      last_bit_q <= last_bit_d;
      stop_cnt_q <= stop_cnt_d;
      stop2_q    <= stop2_d;
      data_q     <= data_d;
      o_txd      <= txd_d;
      o_tx_busy  <= busy_d;
      o_tx_done  <= done_d;
      o_overrun  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer; expected line sequences are hand-computed.
module tb_uart_tx_serializer;

  localparam int unsigned DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       din = 8'h00;
  logic             din_valid = 1'b0;
  logic [DIV_W-1:0] baud_div = '0;
  logic [1:0]       data_len = 2'd0;
  logic             stop_2b = 1'b0;
  logic             parity_en = 1'b0;
  logic [1:0]       parity_mode = 2'd0;
  logic             txd, busy, done, ovr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.DIV_W(DIV_W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_din_8b      (din),
    .i_din_valid   (din_valid),
    .o_tx_busy     (busy),
    .i_baud_div    (baud_div),
    .i_data_len    (data_len),
    .i_stop_2b     (stop_2b),
    .i_parity_en   (parity_en),
    .i_parity_mode (parity_mode),
    .o_txd         (txd),
    .o_tx_done     (done),
    .o_overrun     (ovr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Offer one byte at the current negedge, then scramble config to prove it was latched.
  task automatic send(input logic [7:0] b, input logic [DIV_W-1:0] div, input logic [1:0] len,
                      input logic s2, input logic pe, input logic [1:0] pm);
    din = b; baud_div = div; data_len = len; stop_2b = s2; parity_en = pe; parity_mode = pm;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din = ~b; baud_div = div + DIV_W'(5); data_len = ~len; stop_2b = ~s2;
    parity_en = ~pe; parity_mode = ~pm;
  endtask

  // seq holds the line bits in transmission order, left-aligned; poke offers a byte at T+poke.
  task automatic expect_frame(input string tag, input logic [15:0] seq, input int nbits,
                              input int n, input int poke);
    for (int i = 0; i < nbits * n; i++) begin
      check({tag, "_txd"}, 32'(txd), 32'(seq[15 - i / n]));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_ovr"}, 32'(ovr), 32'((poke != 0) && (i == poke)));
      if ((poke != 0) && (i + 1 == poke)) begin
        din_valid = 1'b1;
        din = 8'hFF;
      end else begin
        din_valid = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_end_done"}, 32'(done), 32'd1);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_txd"}, 32'(txd), 32'd1);
    check({tag, "_end_ovr"}, 32'(ovr), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_txd", 32'(txd), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // 8N1, div 4, 0x55
    send(8'h55, 16'd4, 2'd3, 1'b0, 1'b0, 2'd0);
    expect_frame("8n1_55", {10'b0101010101, 6'b0}, 10, 4, 0);
    @(negedge clk);
    check("gap_done", 32'(done), 32'd0);

    // 7E2, div 3, 0xC3
    send(8'hC3, 16'd3, 2'd2, 1'b1, 1'b1, 2'd1);
`ifdef UART_TX_PARITY_EN
    expect_frame("7e2_c3", {11'b01100001111, 5'b0}, 11, 3, 0);
`else
    expect_frame("7e2_c3", {10'b0110000111, 6'b0}, 10, 3, 0);
`endif
    @(negedge clk);

    // 5-bit 0x1F with odd, space, mark parity
    send(8'h1F, 16'd2, 2'd0, 1'b0, 1'b1, 2'd0);
`ifdef UART_TX_PARITY_EN
    expect_frame("5o_1f", {8'b01111101, 8'b0}, 8, 2, 0);
`else
    expect_frame("5o_1f", {7'b0111111, 9'b0}, 7, 2, 0);
`endif
    @(negedge clk);
    send(8'h1F, 16'd2, 2'd0, 1'b0, 1'b1, 2'd2);
`ifdef UART_TX_PARITY_EN
    expect_frame("5s_1f", {8'b01111101, 8'b0}, 8, 2, 0);
`else
    expect_frame("5s_1f", {7'b0111111, 9'b0}, 7, 2, 0);
`endif
    @(negedge clk);
    send(8'h1F, 16'd2, 2'd0, 1'b0, 1'b1, 2'd3);
`ifdef UART_TX_PARITY_EN
    expect_frame("5m_1f", {8'b01111111, 8'b0}, 8, 2, 0);
`else
    expect_frame("5m_1f", {7'b0111111, 9'b0}, 7, 2, 0);
`endif
    @(negedge clk);

    // Overrun at T+5, then back-to-back accept in the done cycle
    send(8'h0F, 16'd4, 2'd3, 1'b0, 1'b0, 2'd0);
    expect_frame("ovr_0f", {10'b0111100001, 6'b0}, 10, 4, 5);
    send(8'h3C, 16'd1, 2'd3, 1'b0, 1'b0, 2'd0);
    expect_frame("b2b_3c", {10'b0001111001, 6'b0}, 10, 1, 0);
    @(negedge clk);

    // div 0 behaves as 1; a mid-frame divisor change waits for the next accept
    send(8'hA5, 16'd0, 2'd3, 1'b0, 1'b0, 2'd0);
    baud_div = 16'd9;
    expect_frame("div0_a5", {10'b0101001011, 6'b0}, 10, 1, 0);
    @(negedge clk);
    send(8'h00, 16'd9, 2'd0, 1'b0, 1'b0, 2'd0);
    expect_frame("div9_00", {7'b0000001, 9'b0}, 7, 9, 0);
    @(negedge clk);

    // Reset at data bit 3, with a colliding byte strobe
    send(8'h55, 16'd4, 2'd3, 1'b0, 1'b0, 2'd0);
    begin
      logic [2:0] head;
      head = 3'b010;
      for (int i = 0; i < 12; i++) begin
        check("pre_rst_txd", 32'(txd), 32'(head[2 - i / 4]));
        @(negedge clk);
      end
    end
    rst = 1'b1;
    din_valid = 1'b1;
    din = 8'h81;
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ovr", 32'(ovr), 32'd0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("post_rst_idle_done", 32'(done), 32'd0);
      check("post_rst_idle_txd", 32'(txd), 32'd1);
      check("post_rst_idle_busy", 32'(busy), 32'd0);
    end
    send(8'hC3, 16'd2, 2'd3, 1'b0, 1'b0, 2'd0);
    expect_frame("post_rst_c3", {10'b0110000111, 6'b0}, 10, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
